a2d_spi_resp: RTL and testbench
===============================

// Module: a2d_spi_resp
// PURPOSE
// - SPI responder that models the 8-channel, 12-bit A2D converter on the other end of A2D_Intf.
//   It is used in full-chip sims and as an FPGA loopback target.
// - Decodes the 16-bit command on MOSI. The channel field is cmd[13:11].
// - Returns {4'h0, chan_val[ptr]} on MISO. ptr is the channel decoded in the PREVIOUS complete transaction.
// - Channel values are held in an internal 8x12 register file, loaded by the bench/top through a write port.
// PARAMETERS
// - RST_VAL  12'hC00  reset value of all 8 channel registers
// - NBITS    16       bits per SPI transaction
// PORTS
// - clk        in   1   system clock
// - rst_n      in   1   asynchronous active-low reset
// - SS_n       in   1   slave select from master, active low; asynchronous to clk
// - SCLK       in   1   SPI clock, idles high; asynchronous to clk
// - MOSI       in   1   command data from master
// - MISO       out  1   response data to master
// - wr_en      in   1   write strobe for the channel register file
// - wr_chnl    in   3   channel to write
// - wr_data    in   12  value to write
// - cmd_vld    out  1   1-clk pulse when a complete NBITS-bit transaction ends
// - last_cmd   out  16  last complete command received
// - trans_cnt  out  8   count of complete transactions; wraps 8'hFF->8'h00
// BEHAVIOUR
// - Reset values:
//   - MISO=0, cmd_vld=0, last_cmd=0, trans_cnt=0, ptr=0.
//   - All channel registers = RST_VAL. Shift registers = 0. State = IDLE.
// - Input synchronisation and edge detect:
//   - SS_n, SCLK and MOSI each pass through a 2-flop synchroniser (SS_n and SCLK preset high at reset).
//   - A third flop on SS_n and SCLK provides edge detect.
//   - Edge-to-action latency is 3 clk. The master must keep each SCLK half-period >= 4 clk.
// - FSM:
//   - IDLE->SHIFT on sync SS_n fall. On that transition, load shft_tx <= {4'h0, chan[ptr]}, bit_cnt <= 0.
//   - SHIFT, on sync SCLK rise: shft_rx <= {shft_rx[14:0], MOSI_sync}; bit_cnt++ (saturate at NBITS).
//   - SHIFT, on sync SCLK fall with bit_cnt != 0: shft_tx <= {shft_tx[14:0], 1'b0}.
//     The fall before the first rise (front porch) does not shift.
//   - SHIFT->IDLE on sync SS_n rise:
//     - If bit_cnt == NBITS: last_cmd <= shft_rx, ptr <= shft_rx[13:11], cmd_vld pulses for 1 clk, trans_cnt++.
//     - Otherwise (aborted transaction): nothing is latched, no pulse, counters unchanged.
// - MISO is combinational from state and shift register:
//   - MISO = shft_tx[15] while in SHIFT.
//   - MISO = 0 in IDLE.
// - Boundary conditions:
//   - wr_en during SHIFT writes the register file immediately, but the in-flight response is unaffected because shft_tx was loaded at the SS_n fall.
//   - wr_en to the channel selected by ptr on the same clk as the SS_n-fall load: the shift register gets the OLD value.
//   - The first transaction after reset returns chan[0].
//   - More than NBITS SCLK rises: bit_cnt saturates. Extra rises still shift shft_rx, so last_cmd holds the final 16 bits.
//   - SS_n rise and SCLK edge in the same clk: the SS_n rise takes priority and the SCLK edge is ignored.
//   - rst_n asserted mid-transaction: immediate return to reset values. The next SS_n fall starts cleanly.
//   - Command bits [15:14] and [10:0] are ignored for channel decode but kept in last_cmd.
// STRUCTURE
// - Package a2d_resp_pkg:
//   - typedef enum logic {IDLE, SHIFT} resp_state_t
//   - localparams CHNL_MSB=13, CHNL_LSB=11, DATA_W=12
// - Sub-module spi_in_sync: 3-flop synchroniser per input, with rise/fall pulse outputs. Instantiated for SS_n, SCLK and MOSI.
// - Top level contains the FSM, the two shift registers, bit_cnt, ptr, trans_cnt and the 8x12 register file.
// TESTING
// - Reset, then write chan5=12'hABC; send cmd 16'h2800 then 16'h0000.
//   -> 1st response 16'h0C00; 2nd response 16'h0ABC; trans_cnt=2; last_cmd=16'h0000.
// - Abort: SS_n high after 7 SCLK rises.
//   -> no cmd_vld, trans_cnt and ptr unchanged; next transaction returns the previous channel's value.
// - wr_en chan[ptr]=12'h123 mid-transaction (old value 12'h456).
//   -> current response 16'h0456; next response 16'h0123.
// - Back-to-back cmds with channels 0,1,2,...,7 (all channels preloaded with distinct values).
//   -> each response equals the previous cmd's channel value; cmd_vld pulses exactly 8 times.
// - 256 complete transactions.
//   -> trans_cnt wraps to 8'h00.
// - Assert rst_n after 9 bits.
//   -> MISO=0, state IDLE, ptr=0; the following full transaction returns chan[0].

Source files
------------

// File: rtl/a2d_resp_pkg.sv
// Shared types and field positions for the A2D SPI responder model.
package a2d_resp_pkg;

   typedef enum logic {IDLE, SHIFT} resp_state_t;

   localparam int CHNL_MSB = 13;
   localparam int CHNL_LSB = 11;
   localparam int DATA_W   = 12;

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchroniser for an asynchronous SPI input plus a third flop
// that yields single-clk rise/fall pulses on the synchronised value.
module spi_in_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_dly;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
         r_dly  <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
         r_dly  <= r_sync;
      end
   end

   assign o_q    = r_sync;
   assign o_rise =  r_sync & ~r_dly;
   assign o_fall = ~r_sync &  r_dly;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder modelling an 8-channel 12-bit A2D: returns the channel named
// by the previous complete command and records command/transaction history.
module a2d_spi_resp
   import a2d_resp_pkg::*;
#(
   parameter logic [DATA_W-1:0] RST_VAL = 12'hC00,
   parameter int                NBITS   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              SCLK,
   input  logic              MOSI,
   output logic              MISO,
   input  logic              wr_en,
   input  logic [2:0]        wr_chnl,
   input  logic [DATA_W-1:0] wr_data,
   output logic              cmd_vld,
   output logic [NBITS-1:0]  last_cmd,
   output logic [7:0]        trans_cnt
);

   localparam int              CNT_W   = $clog2(NBITS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NBITS);

   logic w_ss_rise, w_ss_fall, w_ss_q_unused;
   logic w_sclk_rise, w_sclk_fall, w_sclk_q_unused;
   logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

   resp_state_t       r_state;
   logic [NBITS-1:0]  r_shft_tx;
   logic [NBITS-1:0]  r_shft_rx;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [2:0]        r_ptr;
   logic [7:0]        r_trans_cnt;
   logic [NBITS-1:0]  r_last_cmd;
   logic              r_cmd_vld;
   logic [DATA_W-1:0] r_chan [8];

   spi_in_sync #(.RST_VAL(1'b1)) u_ss_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_d    (SS_n),
      .o_q    (w_ss_q_unused),
      .o_rise (w_ss_rise),
      .o_fall (w_ss_fall)
   );

   spi_in_sync #(.RST_VAL(1'b1)) u_sclk_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_d    (SCLK),
      .o_q    (w_sclk_q_unused),
      .o_rise (w_sclk_rise),
      .o_fall (w_sclk_fall)
   );

   spi_in_sync #(.RST_VAL(1'b0)) u_mosi_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_d    (MOSI),
      .o_q    (w_mosi),
      .o_rise (w_mosi_rise_unused),
      .o_fall (w_mosi_fall_unused)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) r_chan[i] <= RST_VAL;
      end else if (wr_en) begin
         r_chan[wr_chnl] <= wr_data;
      end
   end

   // SS_n rise is checked first so a coincident SCLK edge is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_shft_tx   <= '0;
         r_shft_rx   <= '0;
         r_bit_cnt   <= '0;
         r_ptr       <= '0;
         r_trans_cnt <= '0;
         r_last_cmd  <= '0;
         r_cmd_vld   <= 1'b0;
      end else begin
         r_cmd_vld <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_ss_fall) begin
                  r_state   <= SHIFT;
                  r_shft_tx <= {{(NBITS-DATA_W){1'b0}}, r_chan[r_ptr]};
                  r_bit_cnt <= '0;
               end
            end
            SHIFT: begin
               if (w_ss_rise) begin
                  r_state <= IDLE;
                  if (r_bit_cnt == CNT_MAX) begin
                     r_last_cmd  <= r_shft_rx;
                     r_ptr       <= r_shft_rx[CHNL_MSB:CHNL_LSB];
                     r_cmd_vld   <= 1'b1;
                     r_trans_cnt <= r_trans_cnt + 8'd1;
                  end
               end else if (w_sclk_rise) begin
                  r_shft_rx <= {r_shft_rx[NBITS-2:0], w_mosi};
                  if (r_bit_cnt != CNT_MAX) r_bit_cnt <= r_bit_cnt + 1'b1;
               end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
                  r_shft_tx <= {r_shft_tx[NBITS-2:0], 1'b0};
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign MISO      = (r_state == SHIFT) & r_shft_tx[NBITS-1];
   assign cmd_vld   = r_cmd_vld;
   assign last_cmd  = r_last_cmd;
   assign trans_cnt = r_trans_cnt;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Bench for a2d_spi_resp: bit-banged SPI master, reference model of the
// channel file / pointer / counters, and a response scoreboard.
module tb_a2d_spi_resp;

   localparam int HALF = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        SS_n, SCLK, MOSI, MISO;
   logic        wr_en;
   logic [2:0]  wr_chnl;
   logic [11:0] wr_data;
   logic        cmd_vld;
   logic [15:0] last_cmd;
   logic [7:0]  trans_cnt;

   a2d_spi_resp dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .SS_n      (SS_n),
      .SCLK      (SCLK),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .wr_en     (wr_en),
      .wr_chnl   (wr_chnl),
      .wr_data   (wr_data),
      .cmd_vld   (cmd_vld),
      .last_cmd  (last_cmd),
      .trans_cnt (trans_cnt)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int vld_cnt = 0;

   always @(posedge clk) if (cmd_vld === 1'b1) vld_cnt <= vld_cnt + 1;

   logic [11:0] m_chan [8];
   logic [2:0]  m_ptr;
   logic [7:0]  m_cnt;
   logic [15:0] m_last;
   int          m_vld;
   logic [15:0] sb [$];

   typedef struct {
      logic [15:0] cmd;
      logic [11:0] val;
      logic [15:0] exp;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_chan[i] = 12'hC00;
      m_ptr  = 3'd0;
      m_cnt  = 8'd0;
      m_last = 16'h0000;
   endtask

   task automatic wr(input logic [2:0] ch, input logic [11:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_chnl = ch; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
      m_chan[ch] = d;
   endtask

   // bits are sent MSB-first from bits[nbits-1]; wr_load writes chan[ptr]
   // on the clk the responder loads its shift register.
   task automatic xfer(input logic [31:0] bits, input int nbits, input bit finish_ss,
                       input bit wr_load, input logic [11:0] wdat, input bit coinc,
                       output logic [15:0] resp);
      bit full;
      logic [15:0] exp_r;
      full = (nbits >= 16);
      resp = 16'h0000;
      if (full) sb.push_back({4'h0, m_chan[m_ptr]});
      @(negedge clk);
      SS_n = 1'b0;
      if (wr_load) begin
         @(negedge clk); @(negedge clk);
         wr_en = 1'b1; wr_chnl = m_ptr; wr_data = wdat;
         @(negedge clk);
         wr_en = 1'b0;
         m_chan[m_ptr] = wdat;
         repeat (HALF - 3) @(negedge clk);
      end else begin
         repeat (HALF) @(negedge clk);
      end
      for (int i = 0; i < nbits; i++) begin
         SCLK = 1'b0;
         MOSI = bits[nbits-1-i];
         repeat (HALF) @(negedge clk);
         if (i < 16) resp[15-i] = MISO;
         SCLK = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      if (!finish_ss) return;
      if (coinc) begin
         SCLK = 1'b0;
         MOSI = ~bits[0];
         repeat (HALF) @(negedge clk);
         SCLK = 1'b1;
         SS_n = 1'b1;
      end else begin
         SS_n = 1'b1;
      end
      repeat (HALF + 1) @(negedge clk);
      if (full) begin
         m_ptr  = bits[13:11];
         m_last = bits[15:0];
         m_cnt  = m_cnt + 8'd1;
         m_vld++;
         if (sb.size() == 0) begin
            chk("sb_empty", 32'(resp), 32'hFFFF_FFFF);
         end else begin
            exp_r = sb.pop_front();
            chk("resp", 32'(resp), 32'(exp_r));
         end
      end
      chk("last_cmd", 32'(last_cmd), 32'(m_last));
      chk("trans_cnt", 32'(trans_cnt), 32'(m_cnt));
      chk("vld_cnt", 32'(vld_cnt), 32'(m_vld));
   endtask

   initial begin
      logic [15:0] r;
      int          v0;
      int          n;

      rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
      wr_en = 1'b0; wr_chnl = 3'd0; wr_data = 12'h000;
      model_reset();
      m_vld = 0;
      repeat (3) @(negedge clk);
      chk("rst_miso", 32'(MISO), 32'h0);
      chk("rst_cmd_vld", 32'(cmd_vld), 32'h0);
      chk("rst_last_cmd", 32'(last_cmd), 32'h0);
      chk("rst_trans_cnt", 32'(trans_cnt), 32'h0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Basic: first response is chan[0] reset value, second is chan5.
      wr(3'd5, 12'hABC);
      xfer(32'h2800, 16, 1, 0, 12'h0, 0, r);
      chk("first_resp", 32'(r), 32'h0C00);
      xfer(32'h0000, 16, 1, 0, 12'h0, 0, r);
      chk("second_resp", 32'(r), 32'h0ABC);
      chk("cnt_after_two", 32'(trans_cnt), 32'd2);
      chk("last_after_two", 32'(last_cmd), 32'h0000);

      // Abort after 7 rises leaves pointer on chan3.
      wr(3'd3, 12'h777);
      xfer(32'h1800, 16, 1, 0, 12'h0, 0, r);
      xfer(32'h3000, 7, 1, 0, 12'h0, 0, r);
      chk("abort_miso_idle", 32'(MISO), 32'h0);
      xfer(32'h1000, 16, 1, 0, 12'h0, 0, r);
      chk("after_abort", 32'(r), 32'h0777);

      // Mid-transaction write to chan[ptr] does not disturb in-flight data.
      wr(3'd2, 12'h456);
      fork
         xfer(32'h1000, 16, 1, 0, 12'h0, 0, r);
         begin
            repeat (60) @(negedge clk);
            wr(3'd2, 12'h123);
         end
      join
      chk("mid_wr_cur", 32'(r), 32'h0456);
      xfer(32'h1000, 16, 1, 0, 12'h0, 0, r);
      chk("mid_wr_next", 32'(r), 32'h0123);

      // Write on the same clk as the shift-register load.
      xfer(32'h1000, 16, 1, 1, 12'h5E5, 0, r);
      chk("load_collide_old", 32'(r), 32'h0123);

      // 18 rises: last_cmd keeps the final 16 bits (0xC800 -> channel 1).
      xfer(32'h0003_C800, 18, 1, 0, 12'h0, 0, r);
      chk("overlong_resp", 32'(r), 32'h05E5);
      chk("overlong_last", 32'(last_cmd), 32'hC800);

      // Table: back-to-back commands through channels 0..7.
      for (int i = 0; i < 8; i++) begin
         tbl[i].val = 12'h300 + 12'(i * 17);
         tbl[i].cmd = {2'b10, 3'(i), 11'h155};
      end
      for (int i = 0; i < 8; i++) wr(3'(i), tbl[i].val);
      tbl[0].exp = {4'h0, tbl[m_ptr].val};
      for (int i = 1; i < 8; i++) tbl[i].exp = {4'h0, tbl[i-1].val};
      v0 = vld_cnt;
      for (int i = 0; i < 8; i++) begin
         xfer(32'(tbl[i].cmd), 16, 1, 0, 12'h0, 0, r);
         chk($sformatf("tbl_resp%0d", i), 32'(r), 32'(tbl[i].exp));
      end
      chk("tbl_vld_pulses", 32'(vld_cnt - v0), 32'd8);

      // SS_n rise coincident with an SCLK rise: the rise is ignored.
      xfer(32'h3A5A, 16, 1, 0, 12'h0, 1, r);
      chk("coinc_resp", 32'(r), 32'(16'h0300 + 16'd119));
      chk("coinc_last", 32'(last_cmd), 32'h3A5A);

      // Run the counter up to its wrap point.
      n = 256 - int'(m_cnt);
      for (int i = 0; i < n; i++)
         xfer(32'({5'b0, 3'((i % 7) + 1), 8'(i)}), 16, 1, 0, 12'h0, 0, r);
      chk("trans_cnt_wrap", 32'(trans_cnt), 32'h00);

      // Reset in the middle of a transaction after 9 bits.
      wr(3'd0, 12'h999);
      xfer(32'h2000, 16, 1, 0, 12'h0, 0, r);
      xfer(32'h2000, 9, 0, 0, 12'h0, 0, r);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_miso", 32'(MISO), 32'h0);
      chk("midrst_cnt", 32'(trans_cnt), 32'h0);
      chk("midrst_last", 32'(last_cmd), 32'h0);
      chk("midrst_vld", 32'(cmd_vld), 32'h0);
      SS_n = 1'b1; SCLK = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (5) @(negedge clk);
      chk("postrst_miso", 32'(MISO), 32'h0);
      xfer(32'h0800, 16, 1, 0, 12'h0, 0, r);
      chk("postrst_resp", 32'(r), 32'h0C00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
